// File: rtl/multiword_adder_seq.sv
// Multi-byte add/subtract sequencer built around one shared 8-bit
// carry-lookahead adder; one byte per clock, LSB first.

module cla8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_c,
  output logic [7:0] o_s,
  output logic       o_c
);

  logic [7:0] w_p;
  logic [7:0] w_g;
  logic [8:0] w_c;
  logic       w_t;
  logic       w_pp;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Each carry is a flat sum of generate/propagate products.
  always_comb begin
    w_c    = '0;
    w_c[0] = i_c;
    w_t    = 1'b0;
    w_pp   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_t  = w_g[i];
      w_pp = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_t  = w_t | (w_pp & w_g[j]);
        w_pp = w_pp & w_p[j];
      end
      w_c[i+1] = w_t | (w_pp & i_c);
    end
  end

  assign o_s = w_p ^ w_c[7:0];
  assign o_c = w_c[8];

endmodule

module multiword_adder_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  overflow
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;

  logic [7:0]    w_a_byte;
  logic [7:0]    w_b_byte;
  logic [7:0]    w_s;
  logic          w_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_next = (r_idx == LAST) ? S_DONE : S_RUN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_byte = r_a[8*i +: 8];
        w_b_byte = r_b[8*i +: 8];
      end
    end
  end

  cla8 u_cla (
    .i_a (w_a_byte),
    .i_b (w_b_byte),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // Subtraction is a + ~b + 1, so b is inverted at capture time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IW'(i)) r_sum[8*i +: 8] <= w_s;
          end
          r_carry <= w_c;
          if (r_idx == LAST) begin
            r_cout <= w_c;
            r_ovf  <= w_c ^ (r_a[W-1] ^ r_b[W-1] ^ w_s[7]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Bench for multiword_adder_seq: NBYTES = 1, 4 and 16 instances checked
// against a plain-arithmetic reference model every cycle.

module tb_multiword_adder_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_v [3];
  logic         sub_v   [3];
  logic         cin_v   [3];
  logic [127:0] a_v     [3];
  logic [127:0] b_v     [3];
  logic [2:0]   busy_p;
  logic [2:0]   done_p;
  logic [2:0]   cout_p;
  logic [2:0]   ovf_p;
  logic [383:0] sum_p;

  int n_vec = 0;
  int n_err = 0;

  int           cnt   [3];
  logic [127:0] e_sum [3];
  bit           e_cout[3];
  bit           e_ovf [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NB = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    logic [8*NB-1:0] w_s;
    multiword_adder_seq #(.NBYTES(NB)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start_v[g]),
      .sub      (sub_v[g]),
      .cin      (cin_v[g]),
      .a        (a_v[g][8*NB-1:0]),
      .b        (b_v[g][8*NB-1:0]),
      .busy     (busy_p[g]),
      .done     (done_p[g]),
      .sum      (w_s),
      .cout     (cout_p[g]),
      .overflow (ovf_p[g])
    );
    assign sum_p[g*128 +: 128] = 128'(w_s);
  end

  function automatic int nb_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
  endfunction

  function automatic logic [127:0] sum_of(input int k);
    return sum_p[k*128 +: 128];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void chk(input string nm, input int k,
                              input logic [127:0] act,
                              input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %h expected %h", nm, k, act, exp);
    end
  endfunction

  // W-bit reference: plain integer add/subtract and sign rules.
  function automatic void ref_op(input int nb, input bit s, input bit c,
                                 input logic [127:0] ai,
                                 input logic [127:0] bi,
                                 output logic [127:0] rs,
                                 output bit rc, output bit ro);
    int           w;
    logic [127:0] mask;
    logic [127:0] av;
    logic [127:0] bv;
    logic [128:0] full;
    bit           sa;
    bit           sb;
    bit           sr;
    w    = 8 * nb;
    mask = (w == 128) ? {128{1'b1}} : ((128'(1) << w) - 128'(1));
    av   = ai & mask;
    bv   = bi & mask;
    if (s) full = {1'b0, av} - {1'b0, bv};
    else   full = {1'b0, av} + {1'b0, bv} + 129'(c);
    rs = full[127:0] & mask;
    sa = av[w-1];
    sb = bv[w-1];
    sr = rs[w-1];
    if (s) begin
      rc = (av >= bv);
      ro = (sa != sb) && (sr != sa);
    end else begin
      rc = full[w];
      ro = (sa == sb) && (sr != sa);
    end
  endfunction

  // Model: an op is accepted when idle; busy for NB+1 cycles, done on last.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        cnt[k]    = 0;
        e_sum[k]  = '0;
        e_cout[k] = 1'b0;
        e_ovf[k]  = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (cnt[k] == 0) begin
          if (start_v[k] === 1'b1) begin
            cnt[k] = nb_of(k) + 1;
            ref_op(nb_of(k), sub_v[k], cin_v[k], a_v[k], b_v[k],
                   e_sum[k], e_cout[k], e_ovf[k]);
          end
        end else begin
          cnt[k] = cnt[k] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("busy", k, 128'(busy_p[k]), 128'(cnt[k] > 0));
      chk("done", k, 128'(done_p[k]), 128'(cnt[k] == 1));
      if (cnt[k] <= 1) begin
        chk("sum", k, sum_of(k), e_sum[k]);
        chk("cout", k, 128'(cout_p[k]), 128'(e_cout[k]));
        chk("ovf", k, 128'(ovf_p[k]), 128'(e_ovf[k]));
      end
    end
  end

  task automatic scramble(input int k, input bit with_start);
    a_v[k]   = rnd128();
    b_v[k]   = rnd128();
    sub_v[k] = 1'($urandom);
    cin_v[k] = 1'($urandom);
    if (with_start) start_v[k] = 1'($urandom);
  endtask

  task automatic op(input int k, input bit s, input bit c,
                    input logic [127:0] ai, input logic [127:0] bi,
                    input bit scr,
                    output logic [127:0] rs, output bit rc,
                    output bit ro, output int lat, output int nbusy);
    bit got;
    got   = 1'b0;
    lat   = -1;
    nbusy = 0;
    rs    = '0;
    rc    = 1'b0;
    ro    = 1'b0;
    @(posedge clk);
    #1;
    start_v[k] = 1'b1;
    sub_v[k]   = s;
    cin_v[k]   = c;
    a_v[k]     = ai;
    b_v[k]     = bi;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    if (scr) scramble(k, 1'b0);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (busy_p[k]) nbusy++;
      if (done_p[k]) begin
        got        = 1'b1;
        lat        = i;
        rs         = sum_of(k);
        rc         = cout_p[k];
        ro         = ovf_p[k];
        start_v[k] = 1'b0;
      end else if (scr) begin
        scramble(k, 1'b1);
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout inst%0d: no done within 40 cycles", k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dop(input string nm, input int k, input bit s,
                     input bit c, input logic [127:0] ai,
                     input logic [127:0] bi, input logic [127:0] xs,
                     input bit xc, input bit xo);
    logic [127:0] rs;
    bit           rc;
    bit           ro;
    int           lat;
    int           nb;
    op(k, s, c, ai, bi, 1'b0, rs, rc, ro, lat, nb);
    chk({nm, "_sum"}, k, rs, xs);
    chk({nm, "_cout"}, k, 128'(rc), 128'(xc));
    chk({nm, "_ovf"}, k, 128'(ro), 128'(xo));
    chk({nm, "_lat"}, k, 128'(lat), 128'(nb_of(k)));
    chk({nm, "_busy"}, k, 128'(nb), 128'(nb_of(k) + 1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rs;
    bit           rc;
    bit           ro;
    int           lat;
    int           nb;
    int           dc [$];
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      sub_v[k]   = 1'b0;
      cin_v[k]   = 1'b0;
      a_v[k]     = '0;
      b_v[k]     = '0;
    end
    #23;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 1, 128'(busy_p[1]), 128'(0));
    chk("rst_done", 1, 128'(done_p[1]), 128'(0));
    chk("rst_sum", 1, sum_of(1), 128'(0));

    dop("add_ff", 1, 0, 0, 128'h000000FF, 128'h1, 128'h00000100, 0, 0);
    dop("add_wrap", 1, 0, 0, 128'hFFFFFFFF, 128'h1, 128'h0, 1, 0);
    dop("add_ovf", 1, 0, 1, 128'h7FFFFFFF, 128'h0, 128'h80000000, 0, 1);
    dop("sub_brw", 1, 1, 0, 128'h5, 128'h7, 128'hFFFFFFFE, 0, 0);
    dop("sub_ovf", 1, 1, 0, 128'h80000000, 128'h1, 128'h7FFFFFFF, 1, 1);
    dop("nb1_add", 0, 0, 0, 128'hC8, 128'h64, 128'h2C, 1, 0);
    dop("nb16_wrap", 2, 0, 0, {128{1'b1}}, 128'h1, 128'h0, 1, 0);

    // Start held high with operands changing every cycle.
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      start_v[1] = 1'b1;
      scramble(1, 1'b0);
      @(negedge clk);
      if (done_p[1]) dc.push_back(i);
    end
    start_v[1] = 1'b0;
    chk("held_ndone", 1, 128'(dc.size() >= 4), 128'(1));
    for (int i = 1; i < dc.size(); i++)
      chk("held_gap", 1, 128'(dc[i] - dc[i-1]), 128'(6));
    for (int i = 0; i < 10 && busy_p[1]; i++) @(negedge clk);

    // Asynchronous reset mid-RUN with idx = 2.
    @(posedge clk);
    #1;
    start_v[1] = 1'b1;
    sub_v[1]   = 1'b0;
    cin_v[1]   = 1'b0;
    a_v[1]     = 128'h01010101;
    b_v[1]     = 128'h01010101;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("pre_rst_sum", 1, sum_of(1), 128'h00000202);
    reset = 1'b1;
    #1;
    chk("arst_busy", 1, 128'(busy_p[1]), 128'(0));
    chk("arst_done", 1, 128'(done_p[1]), 128'(0));
    chk("arst_sum", 1, sum_of(1), 128'(0));
    chk("arst_cout", 1, 128'(cout_p[1]), 128'(0));
    chk("arst_ovf", 1, 128'(ovf_p[1]), 128'(0));
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_done", 1, 128'(done_p[1]), 128'(0));
    end
    dop("post_rst", 1, 0, 0, 128'h12345678, 128'h11111111,
        128'h23456789, 0, 0);

    // Random regression; the compare process checks every result.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        op(k, 1'($urandom), 1'($urandom), rnd128(), rnd128(),
           1'($urandom), rs, rc, ro, lat, nb);
        chk("rnd_lat", k, 128'(lat), 128'(nb_of(k)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
